ooo_top: RTL and testbench



---
 rtl/ooo_pkg.sv | 66 ++++++
 rtl/bram_sp.sv | 23 ++
 rtl/ooo_skid_buffer.sv | 54 +++++
 rtl/ooo_top.sv | 198 +++++++++++++++++++
 tb/tb_ooo_top.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared types, opcode constants and the decode helper for the in-order front end
// of the out-of-order core.
package ooo_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int unsigned NUM_ARCH   = 32;
    localparam int unsigned FREE_DEPTH = 96;
    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned RS_DEPTH   = 8;
    localparam int unsigned IMEM_DEPTH = 128;

    typedef logic [6:0] preg_t;
    typedef logic [3:0] rob_tag_t;
    typedef logic [4:0] arch_reg_t;
    typedef logic [8:0] pc_t;

    typedef enum logic [1:0] {ALU, LSU, BRANCH} fu_class_e;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] instr;
        fu_class_e   fu;
        arch_reg_t   rs1;
        arch_reg_t   rs2;
        arch_reg_t   rd;
        preg_t       prs1;
        preg_t       prs2;
        preg_t       prd;
        rob_tag_t    rob_tag;
        logic        writes_rd;
    } renamed_uop_t;

    typedef struct packed {
        logic      valid;
        fu_class_e fu;
        logic      writes_rd;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t d;
        logic    wr;
        d.valid = 1'b1;
        d.fu    = ALU;
        wr      = 1'b1;
        case (instr[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: d.fu = ALU;
            OPC_LOAD:          d.fu = LSU;
            OPC_STORE:         begin d.fu = LSU;    wr = 1'b0; end
            OPC_BRANCH:        begin d.fu = BRANCH; wr = 1'b0; end
            OPC_JAL, OPC_JALR: d.fu = BRANCH;
            default:           begin d.valid = 1'b0; wr = 1'b0; end
        endcase
        d.writes_rd = wr && (instr[11:7] != '0);
        return d;
    endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous-read block RAM (vendor IP model); read data holds while en is low.
module bram_sp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ooo_skid_buffer.sv
// Two-entry valid/ready buffer; in_ready is a register so no ready path reaches the producer.
module skid_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T           entries [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_n;
    logic       push;
    logic       pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = entries[rd_ptr];

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                entries[wr_ptr] <= in_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count_n;
            in_ready <= (count_n != 2'd2);
        end
    end

endmodule

// File: rtl/ooo_top.sv
// In-order front end: BRAM fetch, decode, rename (RAT + free list + ROB tag),
// skid buffer and dispatch allocation against ROB/RS occupancy.
module ooo_top
    import ooo_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input logic clk,
    input logic rst
);

    // Fetch
    pc_t  pc;
    pc_t  f_pc;
    logic f_valid;
    T     fetch_word;
    logic fetch_adv;

    // Decode
    decode_t     dec;
    logic        d_valid;
    pc_t         d_pc;
    logic [31:0] d_instr;
    fu_class_e   d_fu;
    logic        d_writes_rd;
    logic        d_ready;

    // Rename
    preg_t        rat     [NUM_ARCH];
    preg_t        fl_mem  [FREE_DEPTH];
    logic [6:0]   fl_head;
    logic [6:0]   fl_count;
    logic         fl_empty;
    rob_tag_t     next_tag;
    renamed_uop_t ren_uop;
    logic         rename_fire;
    logic         r_valid;
    logic         r_take;
    renamed_uop_t r_uop;

    // Skid / dispatch
    logic         skid_in_ready;
    renamed_uop_t skid_out;
    logic         skid_to_dispatch_valid;
    pc_t          skid_to_dispatch_pc;
    rob_tag_t     skid_to_dispatch_rob_tag;
    preg_t        skid_to_dispatch_prd;
    logic         dispatch_alloc_rob;
    logic         dispatch_alloc_alu;
    logic         dispatch_alloc_lsu;
    logic         dispatch_alloc_branch;
    logic         rs_full;
    logic [4:0]   rob_count;
    logic [3:0]   alu_count;
    logic [3:0]   lsu_count;
    logic [3:0]   br_count;
    logic         unused_uop_bits;

    assign fl_empty    = (fl_count == 7'd0);
    assign r_take      = !r_valid || skid_in_ready;
    assign rename_fire = d_valid && r_take && !(d_writes_rd && fl_empty);
    assign d_ready     = !d_valid || rename_fire;
    assign fetch_adv   = !f_valid || d_ready;

    bram_sp #(
        .WIDTH($bits(T)),
        .DEPTH(IMEM_DEPTH)
    ) instruction_memory (
        .clk  (clk),
        .en   (fetch_adv),
        .we   (1'b0),
        .addr (pc[8:2]),
        .din  ('0),
        .dout (fetch_word)
    );

    // The BRAM output belongs to f_pc; it holds while fetch is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            f_pc    <= '0;
            f_valid <= 1'b0;
        end else if (fetch_adv) begin
            f_valid <= 1'b1;
            f_pc    <= pc;
            pc      <= pc + 9'd4;
        end
    end

    assign dec = decode_instr(fetch_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid     <= 1'b0;
            d_pc        <= '0;
            d_instr     <= '0;
            d_fu        <= ALU;
            d_writes_rd <= 1'b0;
        end else if (d_ready) begin
            d_valid     <= f_valid && dec.valid;
            d_pc        <= f_pc;
            d_instr     <= fetch_word;
            d_fu        <= dec.fu;
            d_writes_rd <= dec.writes_rd;
        end
    end

    // Single-wide rename: an older write lands in the RAT at the edge before the next read.
    always_comb begin
        ren_uop           = '0;
        ren_uop.pc        = d_pc;
        ren_uop.instr     = d_instr;
        ren_uop.fu        = d_fu;
        ren_uop.rs1       = d_instr[19:15];
        ren_uop.rs2       = d_instr[24:20];
        ren_uop.rd        = d_instr[11:7];
        ren_uop.prs1      = rat[d_instr[19:15]];
        ren_uop.prs2      = rat[d_instr[24:20]];
        ren_uop.prd       = d_writes_rd ? fl_mem[fl_head] : '0;
        ren_uop.rob_tag   = next_tag;
        ren_uop.writes_rd = d_writes_rd;
    end

    // Nothing commits here, so the free list only ever pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_uop    <= '0;
            fl_head  <= '0;
            fl_count <= 7'(FREE_DEPTH);
            next_tag <= '0;
            for (int unsigned i = 0; i < NUM_ARCH; i++) rat[i] <= preg_t'(i);
            for (int unsigned i = 0; i < FREE_DEPTH; i++) fl_mem[i] <= preg_t'(NUM_ARCH + i);
        end else begin
            if (r_take) begin
                r_valid <= rename_fire;
                r_uop   <= ren_uop;
            end
            if (rename_fire) begin
                next_tag <= next_tag + 4'd1;
                if (d_writes_rd) begin
                    rat[d_instr[11:7]] <= fl_mem[fl_head];
                    fl_head  <= (fl_head == 7'(FREE_DEPTH - 1)) ? 7'd0 : fl_head + 7'd1;
                    fl_count <= fl_count - 7'd1;
                end
            end
        end
    end

    skid_buffer #(
        .T(renamed_uop_t)
    ) skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_valid),
        .in_ready  (skid_in_ready),
        .in_data   (r_uop),
        .out_valid (skid_to_dispatch_valid),
        .out_ready (dispatch_alloc_rob),
        .out_data  (skid_out)
    );

    assign skid_to_dispatch_pc      = skid_out.pc;
    assign skid_to_dispatch_rob_tag = skid_out.rob_tag;
    assign skid_to_dispatch_prd     = skid_out.prd;
    assign unused_uop_bits = ^{skid_out.instr, skid_out.rs1, skid_out.rs2, skid_out.rd,
                               skid_out.prs1, skid_out.prs2, skid_out.writes_rd};

    always_comb begin
        rs_full = 1'b1;
        case (skid_out.fu)
            ALU:     rs_full = (alu_count == 4'(RS_DEPTH));
            LSU:     rs_full = (lsu_count == 4'(RS_DEPTH));
            BRANCH:  rs_full = (br_count == 4'(RS_DEPTH));
            default: rs_full = 1'b1;
        endcase
        dispatch_alloc_rob    = !rst && skid_to_dispatch_valid &&
                                (rob_count < 5'(ROB_DEPTH)) && !rs_full;
        dispatch_alloc_alu    = dispatch_alloc_rob && (skid_out.fu == ALU);
        dispatch_alloc_lsu    = dispatch_alloc_rob && (skid_out.fu == LSU);
        dispatch_alloc_branch = dispatch_alloc_rob && (skid_out.fu == BRANCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_count <= '0;
            alu_count <= '0;
            lsu_count <= '0;
            br_count  <= '0;
        end else begin
            if (dispatch_alloc_rob)    rob_count <= rob_count + 5'd1;
            if (dispatch_alloc_alu)    alu_count <= alu_count + 4'd1;
            if (dispatch_alloc_lsu)    lsu_count <= lsu_count + 4'd1;
            if (dispatch_alloc_branch) br_count  <= br_count + 4'd1;
        end
    end

endmodule

// File: tb/tb_ooo_top.sv
// Directed bench for ooo_top: loads small programs into the instruction BRAM and checks
// the dispatch stream, back-pressure limits, mid-stream reset and dropped opcodes.
module tb_ooo_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ooo_top dut (
        .clk (clk),
        .rst (rst)
    );

    localparam logic [31:0] I_ADDI_X1 = 32'h00A00093; // addi x1,x0,10
    localparam logic [31:0] I_LW      = 32'h0080A103; // lw   x2,8(x1)
    localparam logic [31:0] I_SW      = 32'h0020A623; // sw   x2,12(x1)
    localparam logic [31:0] I_BEQ     = 32'h00208863; // beq  x1,x2,16
    localparam logic [31:0] I_LUI     = 32'h010001B7; // lui  x3,0x1000
    localparam logic [31:0] I_NOP     = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_LW0     = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADDI_X5 = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] I_BEQ0    = 32'h00000463; // beq  x0,x0,8
    localparam logic [31:0] I_ADDI_X4 = 32'h00100213; // addi x4,x0,1

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] prog [128];

    typedef struct {
        logic [8:0] pc;
        logic [3:0] tag;
        logic [6:0] prd;
        logic [6:0] prs1;
        logic [6:0] prs2;
        logic [2:0] cls;   // {alu, lsu, branch}
    } disp_t;

    disp_t log_q [$];

    always @(negedge clk) begin
        if (!rst && dut.dispatch_alloc_rob) begin
            log_q.push_back('{dut.skid_to_dispatch_pc, dut.skid_to_dispatch_rob_tag,
                              dut.skid_to_dispatch_prd, dut.skid_out.prs1, dut.skid_out.prs2,
                              {dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu,
                               dut.dispatch_alloc_branch}});
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = '0;
    endtask

    task automatic load_main_prog();
        clear_prog();
        prog[0] = I_ADDI_X1;
        prog[1] = I_LW;
        prog[2] = I_SW;
        prog[3] = I_BEQ;
        prog[4] = I_LUI;
    endtask

    task automatic start_program();
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 128; i++) dut.instruction_memory.mem[i] = prog[i];
        repeat (5) @(posedge clk);
        #2;
        log_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_dispatches(input int unsigned n, input int unsigned budget,
                                   input string name);
        int unsigned c = 0;
        while (log_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (log_q.size() < n) begin
            n_err++;
            $display("FAIL %s timeout: %0d dispatches seen, %0d required", name, log_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({dut.dispatch_alloc_rob, dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu,
             dut.dispatch_alloc_branch} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_alloc: got %b want 0000", {dut.dispatch_alloc_rob,
                     dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu, dut.dispatch_alloc_branch});
        end
        n_vec++;
        if (dut.skid_to_dispatch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_skid_valid: got %b want 0", dut.skid_to_dispatch_valid);
        end
        n_vec++;
        if (dut.pc !== 9'h000) begin
            n_err++;
            $display("FAIL reset_pc: got %h want 000", dut.pc);
        end
    endtask

    task automatic test_program();
        logic [8:0] exp_pc  [5] = '{9'h00, 9'h04, 9'h08, 9'h0C, 9'h10};
        logic [6:0] exp_prd [5] = '{7'd32, 7'd33, 7'd0, 7'd0, 7'd34};
        logic [2:0] exp_cls [5] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
        int unsigned c = 0;
        load_main_prog();
        start_program();
        while (!dut.skid_to_dispatch_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (!dut.skid_to_dispatch_valid || c > 6) begin
            n_err++;
            $display("FAIL first_valid_latency: got %0d cycles want <= 6", c);
        end
        wait_dispatches(5, 40, "program");
        for (int i = 0; i < 5; i++) begin
            if (log_q.size() > i) begin
                n_vec++;
                if (log_q[i].pc !== exp_pc[i] || log_q[i].tag !== 4'(i) ||
                    log_q[i].prd !== exp_prd[i] || log_q[i].cls !== exp_cls[i]) begin
                    n_err++;
                    $display("FAIL program[%0d]: got pc=%h tag=%0d prd=%0d cls=%b want pc=%h tag=%0d prd=%0d cls=%b",
                             i, log_q[i].pc, log_q[i].tag, log_q[i].prd, log_q[i].cls,
                             exp_pc[i], i, exp_prd[i], exp_cls[i]);
                end
            end
        end
        // LW/SW/BEQ read x1 -> P32 and (SW, BEQ) x2 -> P33 from the RAT.
        if (log_q.size() >= 4) begin
            n_vec++;
            if (log_q[1].prs1 !== 7'd32 || log_q[2].prs1 !== 7'd32 || log_q[2].prs2 !== 7'd33 ||
                log_q[3].prs1 !== 7'd32 || log_q[3].prs2 !== 7'd33) begin
                n_err++;
                $display("FAIL rat_sources: got lw.prs1=%0d sw=%0d/%0d beq=%0d/%0d want 32 32/33 32/33",
                         log_q[1].prs1, log_q[2].prs1, log_q[2].prs2, log_q[3].prs1, log_q[3].prs2);
            end
        end
    endtask

    task automatic test_x0_dest();
        clear_prog();
        prog[0] = I_NOP;
        prog[1] = I_ADDI_X1;
        start_program();
        wait_dispatches(2, 40, "x0_dest");
        if (log_q.size() >= 2) begin
            n_vec++;
            if (log_q[0].pc !== 9'h00 || log_q[0].tag !== 4'd0 || log_q[0].prd !== 7'd0 ||
                log_q[0].cls !== 3'b100) begin
                n_err++;
                $display("FAIL x0_nop: got pc=%h tag=%0d prd=%0d cls=%b want 000 0 0 100",
                         log_q[0].pc, log_q[0].tag, log_q[0].prd, log_q[0].cls);
            end
            n_vec++;
            if (log_q[1].pc !== 9'h04 || log_q[1].tag !== 4'd1 || log_q[1].prd !== 7'd32) begin
                n_err++;
                $display("FAIL x0_head_kept: got pc=%h tag=%0d prd=%0d want 004 1 32",
                         log_q[1].pc, log_q[1].tag, log_q[1].prd);
            end
        end
    endtask

    task automatic check_stalled_head(input string name, input logic [8:0] want_pc,
                                      input logic [3:0] want_tag, input logic [6:0] want_prd);
        logic [8:0] pc_a;
        n_vec++;
        if (dut.skid_to_dispatch_valid !== 1'b1 || dut.skid_to_dispatch_pc !== want_pc ||
            dut.skid_to_dispatch_rob_tag !== want_tag || dut.skid_to_dispatch_prd !== want_prd) begin
            n_err++;
            $display("FAIL %s_head: got v=%b pc=%h tag=%0d prd=%0d want v=1 pc=%h tag=%0d prd=%0d",
                     name, dut.skid_to_dispatch_valid, dut.skid_to_dispatch_pc,
                     dut.skid_to_dispatch_rob_tag, dut.skid_to_dispatch_prd, want_pc, want_tag, want_prd);
        end
        n_vec++;
        if ({dut.dispatch_alloc_rob, dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu,
             dut.dispatch_alloc_branch} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s_alloc: got %b want 0000", name, {dut.dispatch_alloc_rob,
                     dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu, dut.dispatch_alloc_branch});
        end
        pc_a = dut.pc;
        repeat (10) @(negedge clk);
        n_vec++;
        if (dut.pc !== pc_a) begin
            n_err++;
            $display("FAIL %s_pc_hold: got %h want %h", name, dut.pc, pc_a);
        end
    endtask

    task automatic test_lsu_full();
        clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = I_LW0;
        start_program();
        repeat (40) @(negedge clk);
        n_vec++;
        if (log_q.size() != 8) begin
            n_err++;
            $display("FAIL lsu_full_count: got %0d dispatches want 8", log_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (log_q.size() > i) begin
                n_vec++;
                if (log_q[i].cls !== 3'b010 || log_q[i].tag !== 4'(i) || log_q[i].prd !== 7'(32 + i)) begin
                    n_err++;
                    $display("FAIL lsu_full[%0d]: got tag=%0d prd=%0d cls=%b want %0d %0d 010",
                             i, log_q[i].tag, log_q[i].prd, log_q[i].cls, i, 32 + i);
                end
            end
        end
        check_stalled_head("lsu_full", 9'h020, 4'd8, 7'd40);
    endtask

    task automatic test_rob_full();
        clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = (i % 2 == 0) ? I_ADDI_X5 : I_BEQ0;
        // The 17th is a load so only the ROB limit, not an RS limit, can hold it.
        for (int i = 16; i < 28; i++) prog[i] = I_LW0;
        start_program();
        repeat (60) @(negedge clk);
        n_vec++;
        if (log_q.size() != 16) begin
            n_err++;
            $display("FAIL rob_full_count: got %0d dispatches want 16", log_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            if (log_q.size() > i) begin
                n_vec++;
                if (log_q[i].tag !== 4'(i) || log_q[i].pc !== 9'(4 * i) ||
                    log_q[i].cls !== ((i % 2 == 0) ? 3'b100 : 3'b001) ||
                    log_q[i].prd !== ((i % 2 == 0) ? 7'(32 + i / 2) : 7'd0)) begin
                    n_err++;
                    $display("FAIL rob_full[%0d]: got pc=%h tag=%0d prd=%0d cls=%b",
                             i, log_q[i].pc, log_q[i].tag, log_q[i].prd, log_q[i].cls);
                end
            end
        end
        check_stalled_head("rob_full", 9'h040, 4'd0, 7'd40);
    endtask

    task automatic test_mid_reset();
        load_main_prog();
        start_program();
        wait_dispatches(3, 40, "mid_reset_pre");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({dut.dispatch_alloc_rob, dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu,
             dut.dispatch_alloc_branch} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_alloc: got %b want 0000", {dut.dispatch_alloc_rob,
                     dut.dispatch_alloc_alu, dut.dispatch_alloc_lsu, dut.dispatch_alloc_branch});
        end
        @(posedge clk);
        #2;
        log_q.delete();
        rst = 1'b0;
        wait_dispatches(1, 20, "mid_reset_post");
        if (log_q.size() >= 1) begin
            n_vec++;
            if (log_q[0].pc !== 9'h00 || log_q[0].tag !== 4'd0 || log_q[0].prd !== 7'd32 ||
                log_q[0].cls !== 3'b100) begin
                n_err++;
                $display("FAIL mid_reset_first: got pc=%h tag=%0d prd=%0d cls=%b want 000 0 32 100",
                         log_q[0].pc, log_q[0].tag, log_q[0].prd, log_q[0].cls);
            end
        end
    endtask

    task automatic test_drop_and_wrap();
        int unsigned hits = 0;
        load_main_prog();
        prog[6] = I_ADDI_X4;
        start_program();
        wait_dispatches(7, 300, "drop_wrap");
        for (int i = 0; i < 7; i++) begin
            if (log_q.size() > i && log_q[i].pc == 9'h014) hits++;
        end
        n_vec++;
        if (hits != 0) begin
            n_err++;
            $display("FAIL drop_zero_word: got %0d dispatches at pc 014 want 0", hits);
        end
        if (log_q.size() >= 7) begin
            n_vec++;
            if (log_q[5].pc !== 9'h018 || log_q[5].tag !== 4'd5 || log_q[5].prd !== 7'd35 ||
                log_q[5].cls !== 3'b100) begin
                n_err++;
                $display("FAIL drop_next_tag: got pc=%h tag=%0d prd=%0d cls=%b want 018 5 35 100",
                         log_q[5].pc, log_q[5].tag, log_q[5].prd, log_q[5].cls);
            end
            // After 0x1FC the PC wraps to 0 and the program is renamed again.
            n_vec++;
            if (log_q[6].pc !== 9'h000 || log_q[6].tag !== 4'd6 || log_q[6].prd !== 7'd36) begin
                n_err++;
                $display("FAIL pc_wrap: got pc=%h tag=%0d prd=%0d want 000 6 36",
                         log_q[6].pc, log_q[6].tag, log_q[6].prd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_x0_dest();
        test_lsu_full();
        test_rob_full();
        test_mid_reset();
        test_drop_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
